color_centroid: RTL and testbench
=================================

# color_centroid

Consumes the reconstructed RGB565 pixel stream from the camera pixel-reconstruction stage and classifies each pixel against a programmable colour box. The block accumulates per-frame statistics of the matching pixels and computes their centroid with an iterative divider. It reports one centroid result per frame to the ball-tracking logic, and emits a per-pixel mask for the video overlay.

## Interface
- HCOUNT_WIDTH, 11: pixel column width
- VCOUNT_WIDTH, 10: pixel row width
- COUNT_WIDTH, 20: matched-pixel counter width (sized for 1280x720)
- SUM_WIDTH, 32: coordinate accumulator width, which is also the divider iteration count
- clk_in  in  1  system clock; the block has one clock
- rst_in  in  1  reset, synchronous and active-high
- pixel_valid_in  in  1  qualifies pixel_*_in for one cycle
- pixel_hcount_in  in  HCOUNT_WIDTH  column
- pixel_vcount_in  in  VCOUNT_WIDTH  row
- pixel_data_in  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0]
- r_lo_in, r_hi_in  in  5  red bounds (inclusive)
- g_lo_in, g_hi_in  in  6  green bounds (inclusive)
- b_lo_in, b_hi_in  in  5  blue bounds (inclusive)
- mask_valid_out  out  1  registered copy of pixel_valid_in
- mask_out  out  1  pixel matched the colour box
- centroid_valid_out  out  1  one-cycle pulse when a result is ready
- x_out  out  HCOUNT_WIDTH  centroid column
- y_out  out  VCOUNT_WIDTH  centroid row
- count_out  out  COUNT_WIDTH  matched pixels in the frame
- found_out  out  1  count_out != 0
- busy_out  out  1  divider running

## Operation
- Match rule: r_lo<=R<=r_hi && g_lo<=G<=g_hi && b_lo<=B<=b_hi. Comparisons are unsigned. If lo>hi, that channel never matches.
- Thresholds are sampled on every valid pixel and are treated as quasi-static.
- Accumulators:
  - cnt: matched pixels
  - sx: sum of hcount
  - sy: sum of vcount
  - All three update only on a valid matched pixel. Zero-extend the coordinates to SUM_WIDTH.
  - Accumulators saturate at their all-ones value. They do not wrap.
- Frame boundary: a valid pixel with hcount==0 and vcount==0.
  - On that cycle, cnt/sx/sy are snapshotted. The snapshot excludes the (0,0) pixel.
  - The accumulators are then reloaded with the (0,0) pixel's contribution only: cnt=1/sx=0/sy=0 if it matched, otherwise all 0.
- FSM states:
  - IDLE: on a frame boundary, go to DIVIDE if snapshot cnt!=0, otherwise go to DONE with x=y=0 and found=0.
  - DIVIDE: two sub-module instances compute sx/cnt and sy/cnt in parallel over SUM_WIDTH cycles. Go to DONE when both finish.
  - DONE: drive the result registers and pulse centroid_valid_out, then return to IDLE.
- Result truncation: quotients are truncated to HCOUNT_WIDTH/VCOUNT_WIDTH. Because a mean never exceeds the maximum coordinate, truncation loses nothing.
- Frame boundary while not in IDLE: the snapshot is dropped. The accumulators still restart, so the next frame's statistics stay correct. The result in progress completes normally.
- Result registers (x_out, y_out, count_out, found_out) hold their value until the next DONE.
- Reset mid-DIVIDE: abort the division, return to IDLE, and emit no pulse.

## Timing
- Reset values: all outputs 0; accumulators 0; FSM in IDLE.
- Mask: a pixel presented at cycle N gives mask_valid_out/mask_out at N+1.
- Frame boundary at cycle N with cnt!=0:
  - busy_out is high on cycles N+1..N+SUM_WIDTH.
  - centroid_valid_out pulses at N+SUM_WIDTH+1 (N+33 at the defaults).
  - Outputs are stable from the pulse cycle onward.
- Frame boundary at cycle N with cnt==0: centroid_valid_out pulses at N+2. busy_out never rises.
- The block accepts back-to-back valid pixels on every cycle and never stalls. There is no upstream backpressure.

## Configuration
- COLOR_CENTROID_BBOX_EN defined:
  - Adds min/max trackers for the matched pixels' hcount and vcount.
  - Adds the output ports bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out. They are snapshotted at the frame boundary and presented with the centroid_valid_out pulse.
  - When no pixels match, all four outputs are 0.
  - Tracker reset values: min = all-ones, max = 0.
- COLOR_CENTROID_BBOX_EN undefined: no bbox logic and no bbox ports. All other behaviour is identical.

## Structure
- Package color_centroid_pkg holds:
  - The FSM state enum: IDLE, DIVIDE, DONE.
  - The RGB565 field bit-position constants.
  - A packed struct for the six threshold bounds.
- Sub-module iter_divider (restoring, one quotient bit per cycle):
  - Inputs: start, dividend[SUM_WIDTH], divisor[COUNT_WIDTH].
  - Outputs: quotient[SUM_WIDTH], done pulse.
  - Synchronous reset on rst_in.
- The top level instantiates iter_divider twice, once for X and once for Y.

## Test plan
- Mask:
  - Thresholds R 20..31, G 0..63, B 0..31.
  - Pixel 16'hF800 gives mask_out=1 one cycle later. Pixel 16'h07E0 gives mask_out=0.
- Centroid:
  - Frame of 640x480 with matches exactly at (100,50), (102,50), (104,56), then a (0,0) boundary pixel.
  - Required: pulse 33 cycles after the boundary with x_out=102, y_out=52, count_out=3, found_out=1.
- Empty frame:
  - No matches, then a boundary pixel.
  - Required: pulse 2 cycles after the boundary with found_out=0, x_out=0, y_out=0, count_out=0.
- Overrun: a second boundary pixel 10 cycles after the first gives exactly one pulse, and the following frame's result is correct.
- Reset: rst_in is asserted on cycle 15 of DIVIDE. Required: no pulse, busy_out=0 next cycle, all outputs 0.
- BBOX: with COLOR_CENTROID_BBOX_EN defined, the centroid scenario's data gives xmin=100, xmax=104, ymin=50, ymax=56.

Source files
------------

// File: rtl/color_centroid_pkg.sv
// Shared types for color_centroid: FSM states, RGB565 field positions,
// threshold bundle and the colour-box match function.
package color_centroid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } cc_state_e;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [4:0] r_lo;
        logic [4:0] r_hi;
        logic [5:0] g_lo;
        logic [5:0] g_hi;
        logic [4:0] b_lo;
        logic [4:0] b_hi;
    } cc_bounds_t;

    // An inverted range (lo > hi) can never satisfy both compares.
    function automatic logic in_box(input logic [15:0] px, input cc_bounds_t bnd);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = px[R_MSB:R_LSB];
        g = px[G_MSB:G_LSB];
        b = px[B_MSB:B_LSB];
        return (r >= bnd.r_lo) && (r <= bnd.r_hi) &&
               (g >= bnd.g_lo) && (g <= bnd.g_hi) &&
               (b >= bnd.b_lo) && (b <= bnd.b_hi);
    endfunction

endpackage

// File: rtl/color_centroid_divider.sv
// iter_divider: restoring unsigned divider, one quotient bit per cycle.
// The first bit is resolved on the start edge; done_out marks the final quotient.
module iter_divider #(
    parameter int SUM_WIDTH   = 32,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [SUM_WIDTH-1:0]   dividend_in,
    input  logic [COUNT_WIDTH-1:0] divisor_in,
    output logic [SUM_WIDTH-1:0]   quotient_out,
    output logic                   done_out,
    output logic                   busy_out
);

    localparam int IW = $clog2(SUM_WIDTH + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(SUM_WIDTH);

    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic [SUM_WIDTH-1:0]   quo_q, quo_d;
    logic [COUNT_WIDTH-1:0] divisor_q;
    logic [IW-1:0]          iter_q;
    logic                   busy_q;
    logic                   done_q;

    logic [COUNT_WIDTH-1:0] src_rem_s;
    logic [SUM_WIDTH-1:0]   src_quo_s;
    logic [COUNT_WIDTH-1:0] src_div_s;
    logic [COUNT_WIDTH:0]   shifted_s;
    logic                   ge_s;

    // One restoring step on either the fresh operands or the running state.
    always_comb begin
        src_rem_s = start_in ? '0 : rem_q;
        src_quo_s = start_in ? dividend_in : quo_q;
        src_div_s = start_in ? divisor_in : divisor_q;
        shifted_s = {src_rem_s, src_quo_s[SUM_WIDTH-1]};
        ge_s      = shifted_s >= {1'b0, src_div_s};
        if (ge_s) begin
            rem_d = shifted_s[COUNT_WIDTH-1:0] - src_div_s;
        end else begin
            rem_d = shifted_s[COUNT_WIDTH-1:0];
        end
        quo_d = {src_quo_s[SUM_WIDTH-2:0], ge_s};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            iter_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (start_in) begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_in;
            iter_q    <= IW'(1);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else if (busy_q) begin
            if (iter_q != ITER_LAST) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                iter_q <= iter_q + IW'(1);
                done_q <= (iter_q == ITER_LAST - IW'(1));
            end else begin
                busy_q <= 1'b0;
                done_q <= 1'b0;
            end
        end
    end

    assign quotient_out = quo_q;
    assign done_out     = done_q;
    assign busy_out     = busy_q;

endmodule

// File: rtl/color_centroid.sv
// color_centroid: per-pixel colour-box mask plus per-frame centroid of matches.
// Optional bounding-box outputs are enabled with COLOR_CENTROID_BBOX_EN.
module color_centroid
    import color_centroid_pkg::*;
#(
    parameter int HCOUNT_WIDTH = 11,
    parameter int VCOUNT_WIDTH = 10,
    parameter int COUNT_WIDTH  = 20,
    parameter int SUM_WIDTH    = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    pixel_valid_in,
    input  logic [HCOUNT_WIDTH-1:0] pixel_hcount_in,
    input  logic [VCOUNT_WIDTH-1:0] pixel_vcount_in,
    input  logic [15:0]             pixel_data_in,
    input  logic [4:0]              r_lo_in,
    input  logic [4:0]              r_hi_in,
    input  logic [5:0]              g_lo_in,
    input  logic [5:0]              g_hi_in,
    input  logic [4:0]              b_lo_in,
    input  logic [4:0]              b_hi_in,
    output logic                    mask_valid_out,
    output logic                    mask_out,
    output logic                    centroid_valid_out,
    output logic [HCOUNT_WIDTH-1:0] x_out,
    output logic [VCOUNT_WIDTH-1:0] y_out,
    output logic [COUNT_WIDTH-1:0]  count_out,
    output logic                    found_out,
    output logic                    busy_out
`ifdef COLOR_CENTROID_BBOX_EN
    ,
    output logic [HCOUNT_WIDTH-1:0] bbox_xmin_out,
    output logic [HCOUNT_WIDTH-1:0] bbox_xmax_out,
    output logic [VCOUNT_WIDTH-1:0] bbox_ymin_out,
    output logic [VCOUNT_WIDTH-1:0] bbox_ymax_out
`endif
);

    cc_bounds_t bounds_s;
    logic match_s, boundary_s, hit_s, accept_s, start_s;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]   sx_q, sx_d, sy_q, sy_d;
    logic [SUM_WIDTH:0]     sx_sum_s, sy_sum_s;
    logic                   snap_valid_q;
    logic [COUNT_WIDTH-1:0] snap_cnt_q;
    cc_state_e              state_q, state_d;
    logic [SUM_WIDTH-1:0]   qx_s, qy_s;
    logic done_x_s, done_y_s, busy_x_s, busy_y_s;
    logic mask_valid_q, mask_q, valid_q, valid_d, found_q, found_d;
    logic [HCOUNT_WIDTH-1:0] x_q, x_d;
    logic [VCOUNT_WIDTH-1:0] y_q, y_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;

    assign bounds_s   = '{r_lo: r_lo_in, r_hi: r_hi_in, g_lo: g_lo_in,
                          g_hi: g_hi_in, b_lo: b_lo_in, b_hi: b_hi_in};
    assign match_s    = in_box(pixel_data_in, bounds_s);
    assign boundary_s = pixel_valid_in && (pixel_hcount_in == '0) && (pixel_vcount_in == '0);
    assign hit_s      = pixel_valid_in && match_s;
    // A boundary one cycle after an accepted one is still being decided, so it is dropped.
    assign accept_s   = boundary_s && (state_q == IDLE) && !snap_valid_q;
    assign start_s    = accept_s && (cnt_q != '0);

    assign sx_sum_s = {1'b0, sx_q} + {{(SUM_WIDTH + 1 - HCOUNT_WIDTH){1'b0}}, pixel_hcount_in};
    assign sy_sum_s = {1'b0, sy_q} + {{(SUM_WIDTH + 1 - VCOUNT_WIDTH){1'b0}}, pixel_vcount_in};

    // Saturating accumulators, restarted with the boundary pixel's own contribution.
    always_comb begin
        cnt_d = cnt_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        if (boundary_s) begin
            cnt_d = match_s ? COUNT_WIDTH'(1) : '0;
            sx_d  = '0;
            sy_d  = '0;
        end else if (hit_s) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
            sx_d  = sx_sum_s[SUM_WIDTH] ? '1 : sx_sum_s[SUM_WIDTH-1:0];
            sy_d  = sy_sum_s[SUM_WIDTH] ? '1 : sy_sum_s[SUM_WIDTH-1:0];
        end else begin
            cnt_d = cnt_q;
        end
    end

    iter_divider #(.SUM_WIDTH(SUM_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_div_x (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_s), .dividend_in(sx_q),
        .divisor_in(cnt_q), .quotient_out(qx_s), .done_out(done_x_s), .busy_out(busy_x_s)
    );

    iter_divider #(.SUM_WIDTH(SUM_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_div_y (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_s), .dividend_in(sy_q),
        .divisor_in(cnt_q), .quotient_out(qy_s), .done_out(done_y_s), .busy_out(busy_y_s)
    );

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (snap_valid_q) begin
                    state_d = (snap_cnt_q != '0) ? DIVIDE : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                if (done_x_s && done_y_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DIVIDE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: results are registered on entry to DONE so they appear with the pulse.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        count_d = count_q;
        found_d = found_q;
        valid_d = 1'b0;
        if (state_d == DONE) begin
            valid_d = 1'b1;
            count_d = snap_cnt_q;
            found_d = (snap_cnt_q != '0);
            if (snap_cnt_q != '0) begin
                x_d = qx_s[HCOUNT_WIDTH-1:0];
                y_d = qy_s[VCOUNT_WIDTH-1:0];
            end else begin
                x_d = '0;
                y_d = '0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State, accumulators, snapshot and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            snap_valid_q <= 1'b0;
            snap_cnt_q   <= '0;
            mask_valid_q <= 1'b0;
            mask_q       <= 1'b0;
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            count_q      <= '0;
            found_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            snap_valid_q <= accept_s;
            if (accept_s) begin
                snap_cnt_q <= cnt_q;
            end
            mask_valid_q <= pixel_valid_in;
            mask_q       <= hit_s;
            valid_q      <= valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            count_q      <= count_d;
            found_q      <= found_d;
        end
    end

    assign mask_valid_out     = mask_valid_q;
    assign mask_out           = mask_q;
    assign centroid_valid_out = valid_q;
    assign x_out              = x_q;
    assign y_out              = y_q;
    assign count_out          = count_q;
    assign found_out          = found_q;
    assign busy_out           = busy_x_s | busy_y_s;

`ifdef COLOR_CENTROID_BBOX_EN
    logic [HCOUNT_WIDTH-1:0] xmin_q, xmin_d, xmax_q, xmax_d, sxmin_q, sxmax_q, bxmin_q, bxmax_q;
    logic [VCOUNT_WIDTH-1:0] ymin_q, ymin_d, ymax_q, ymax_d, symin_q, symax_q, bymin_q, bymax_q;

    // Min/max trackers; an unmatched boundary pixel leaves them at their empty values.
    always_comb begin
        xmin_d = xmin_q;
        xmax_d = xmax_q;
        ymin_d = ymin_q;
        ymax_d = ymax_q;
        if (boundary_s) begin
            xmin_d = match_s ? '0 : '1;
            ymin_d = match_s ? '0 : '1;
            xmax_d = '0;
            ymax_d = '0;
        end else if (hit_s) begin
            xmin_d = (pixel_hcount_in < xmin_q) ? pixel_hcount_in : xmin_q;
            xmax_d = (pixel_hcount_in > xmax_q) ? pixel_hcount_in : xmax_q;
            ymin_d = (pixel_vcount_in < ymin_q) ? pixel_vcount_in : ymin_q;
            ymax_d = (pixel_vcount_in > ymax_q) ? pixel_vcount_in : ymax_q;
        end else begin
            xmin_d = xmin_q;
        end
    end

    // Tracker, snapshot and bbox output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
            sxmin_q <= '1;
            sxmax_q <= '0;
            symin_q <= '1;
            symax_q <= '0;
            bxmin_q <= '0;
            bxmax_q <= '0;
            bymin_q <= '0;
            bymax_q <= '0;
        end else begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            if (accept_s) begin
                sxmin_q <= xmin_q;
                sxmax_q <= xmax_q;
                symin_q <= ymin_q;
                symax_q <= ymax_q;
            end
            if (state_d == DONE) begin
                bxmin_q <= (snap_cnt_q != '0) ? sxmin_q : '0;
                bxmax_q <= (snap_cnt_q != '0) ? sxmax_q : '0;
                bymin_q <= (snap_cnt_q != '0) ? symin_q : '0;
                bymax_q <= (snap_cnt_q != '0) ? symax_q : '0;
            end
        end
    end

    assign bbox_xmin_out = bxmin_q;
    assign bbox_xmax_out = bxmax_q;
    assign bbox_ymin_out = bymin_q;
    assign bbox_ymax_out = bymax_q;
`endif

endmodule

// File: tb/tb_color_centroid.sv
// Directed bench for color_centroid; inputs change and outputs are sampled on negedge.
// Define COLOR_CENTROID_BBOX_EN to also check the bounding-box outputs.
module tb_color_centroid;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int CW = 20;
    localparam int SW = 32;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] GREEN = 16'h07E0;
    localparam logic [15:0] BLUE  = 16'h001F;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          pixel_valid_in;
    logic [HW-1:0] pixel_hcount_in;
    logic [VW-1:0] pixel_vcount_in;
    logic [15:0]   pixel_data_in;
    logic [4:0]    r_lo_in, r_hi_in, b_lo_in, b_hi_in;
    logic [5:0]    g_lo_in, g_hi_in;
    logic          mask_valid_out, mask_out, centroid_valid_out, found_out, busy_out;
    logic [HW-1:0] x_out;
    logic [VW-1:0] y_out;
    logic [CW-1:0] count_out;
`ifdef COLOR_CENTROID_BBOX_EN
    logic [HW-1:0] bbox_xmin_out, bbox_xmax_out;
    logic [VW-1:0] bbox_ymin_out, bbox_ymax_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    color_centroid #(.HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW), .COUNT_WIDTH(CW), .SUM_WIDTH(SW)) dut (
        .clk_in(clk), .rst_in(rst_in), .pixel_valid_in(pixel_valid_in),
        .pixel_hcount_in(pixel_hcount_in), .pixel_vcount_in(pixel_vcount_in),
        .pixel_data_in(pixel_data_in),
        .r_lo_in(r_lo_in), .r_hi_in(r_hi_in), .g_lo_in(g_lo_in), .g_hi_in(g_hi_in),
        .b_lo_in(b_lo_in), .b_hi_in(b_hi_in),
        .mask_valid_out(mask_valid_out), .mask_out(mask_out),
        .centroid_valid_out(centroid_valid_out), .x_out(x_out), .y_out(y_out),
        .count_out(count_out), .found_out(found_out), .busy_out(busy_out)
`ifdef COLOR_CENTROID_BBOX_EN
        , .bbox_xmin_out(bbox_xmin_out), .bbox_xmax_out(bbox_xmax_out),
        .bbox_ymin_out(bbox_ymin_out), .bbox_ymax_out(bbox_ymax_out)
`endif
    );

    task automatic pix(input int h, input int v, input logic [15:0] d);
        @(negedge clk);
        pixel_valid_in  = 1'b1;
        pixel_hcount_in = h[HW-1:0];
        pixel_vcount_in = v[VW-1:0];
        pixel_data_in   = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_valid_in = 1'b0;
        end
    endtask

    // Observe n cycles after a boundary pixel: k=1 is the cycle after it.
    task automatic run_window(input int n, output int first_k, output int pulses,
                              output logic [63:0] busy_tr);
        first_k = 0;
        pulses  = 0;
        busy_tr = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            pixel_valid_in = 1'b0;
            if (k < 64) busy_tr[k] = busy_out;
            if (centroid_valid_out === 1'b1) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
    endtask

    task automatic set_box_default();
        r_lo_in = 5'd20; r_hi_in = 5'd31;
        g_lo_in = 6'd0;  g_hi_in = 6'd63;
        b_lo_in = 5'd0;  b_hi_in = 5'd31;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        pixel_valid_in = 1'b0; pixel_hcount_in = '0; pixel_vcount_in = '0; pixel_data_in = '0;
        set_box_default();
        repeat (3) @(negedge clk);
        checks++;
        if ({mask_valid_out, mask_out, centroid_valid_out, found_out, busy_out} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000",
                     {mask_valid_out, mask_out, centroid_valid_out, found_out, busy_out});
        end
        checks++;
        if ({x_out, y_out, count_out} !== {HW'(0), VW'(0), CW'(0)}) begin
            failures++;
            $display("FAIL reset_results x=%0d y=%0d count=%0d want all 0", x_out, y_out, count_out);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_mask();
        pix(5, 7, RED);
        pix(6, 7, GREEN);
        checks++;
        if ({mask_valid_out, mask_out} !== 2'b11) begin
            failures++;
            $display("FAIL mask_red got=%b want=11", {mask_valid_out, mask_out});
        end
        pix(7, 7, 16'hA000);
        checks++;
        if ({mask_valid_out, mask_out} !== 2'b10) begin
            failures++;
            $display("FAIL mask_green got=%b want=10", {mask_valid_out, mask_out});
        end
        pix(8, 7, 16'h9800);
        checks++;
        if ({mask_valid_out, mask_out} !== 2'b11) begin
            failures++;
            $display("FAIL mask_r_at_lo got=%b want=11", {mask_valid_out, mask_out});
        end
        idle(1);
        checks++;
        if ({mask_valid_out, mask_out} !== 2'b10) begin
            failures++;
            $display("FAIL mask_r_below_lo got=%b want=10", {mask_valid_out, mask_out});
        end
        idle(1);
        checks++;
        if (mask_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL mask_valid_idle got=%b want=0", mask_valid_out);
        end
        r_lo_in = 5'd25; r_hi_in = 5'd20;
        pix(9, 7, RED);
        idle(1);
        checks++;
        if ({mask_valid_out, mask_out} !== 2'b10) begin
            failures++;
            $display("FAIL mask_inverted_range got=%b want=10", {mask_valid_out, mask_out});
        end
        set_box_default();
    endtask

    task automatic test_centroid();
        int fk, np;
        logic [63:0] bt;
        pix(0, 0, GREEN);
        run_window(40, fk, np, bt);
        pix(5, 5, GREEN);
        pix(100, 50, RED);
        pix(101, 50, GREEN);
        pix(102, 50, RED);
        idle(3);
        pix(104, 56, RED);
        pix(639, 479, GREEN);
        pix(0, 0, GREEN);
        run_window(40, fk, np, bt);
        checks++;
        if (fk != 33 || np != 1) begin
            failures++;
            $display("FAIL centroid_pulse at=%0d count=%0d want at=33 count=1", fk, np);
        end
        checks++;
        if (bt[1] !== 1'b1 || bt[32] !== 1'b1 || bt[33] !== 1'b0) begin
            failures++;
            $display("FAIL centroid_busy k1=%b k32=%b k33=%b want 1 1 0", bt[1], bt[32], bt[33]);
        end
        checks++;
        if (x_out !== 11'd102 || y_out !== 10'd52) begin
            failures++;
            $display("FAIL centroid_xy got=(%0d,%0d) want=(102,52)", x_out, y_out);
        end
        checks++;
        if (count_out !== 20'd3 || found_out !== 1'b1) begin
            failures++;
            $display("FAIL centroid_count got=%0d found=%b want=3 found=1", count_out, found_out);
        end
`ifdef COLOR_CENTROID_BBOX_EN
        checks++;
        if (bbox_xmin_out !== 11'd100 || bbox_xmax_out !== 11'd104 ||
            bbox_ymin_out !== 10'd50 || bbox_ymax_out !== 10'd56) begin
            failures++;
            $display("FAIL bbox got=%0d..%0d,%0d..%0d want=100..104,50..56",
                     bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out);
        end
`endif
    endtask

    task automatic test_empty_frame();
        int fk, np;
        logic [63:0] bt;
        pix(3, 3, GREEN);
        pix(7, 9, BLUE);
        pix(0, 0, GREEN);
        run_window(10, fk, np, bt);
        checks++;
        if (fk != 2 || np != 1) begin
            failures++;
            $display("FAIL empty_pulse at=%0d count=%0d want at=2 count=1", fk, np);
        end
        checks++;
        if (bt !== 64'd0) begin
            failures++;
            $display("FAIL empty_busy got=%h want=0", bt);
        end
        checks++;
        if (found_out !== 1'b0 || x_out !== 11'd0 || y_out !== 10'd0 || count_out !== 20'd0) begin
            failures++;
            $display("FAIL empty_result found=%b x=%0d y=%0d count=%0d want all 0",
                     found_out, x_out, y_out, count_out);
        end
`ifdef COLOR_CENTROID_BBOX_EN
        checks++;
        if ({bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out} !== '0) begin
            failures++;
            $display("FAIL empty_bbox got=%0d..%0d,%0d..%0d want all 0",
                     bbox_xmin_out, bbox_xmax_out, bbox_ymin_out, bbox_ymax_out);
        end
`endif
    endtask

    task automatic test_overrun();
        int fk, np;
        logic [63:0] bt;
        fk = 0;
        np = 0;
        pix(10, 20, RED);
        pix(30, 40, RED);
        pix(0, 0, GREEN);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            pixel_valid_in = 1'b0;
            if (k == 5) begin
                pixel_valid_in = 1'b1; pixel_hcount_in = 11'd500; pixel_vcount_in = 10'd400;
                pixel_data_in = RED;
            end
            if (k == 10) begin
                pixel_valid_in = 1'b1; pixel_hcount_in = 11'd0; pixel_vcount_in = 10'd0;
                pixel_data_in = GREEN;
            end
            if (centroid_valid_out === 1'b1) begin
                np++;
                if (fk == 0) fk = k;
            end
        end
        checks++;
        if (fk != 33 || np != 1) begin
            failures++;
            $display("FAIL overrun_pulse at=%0d count=%0d want at=33 count=1", fk, np);
        end
        checks++;
        if (x_out !== 11'd20 || y_out !== 10'd30 || count_out !== 20'd2) begin
            failures++;
            $display("FAIL overrun_first got=(%0d,%0d) n=%0d want=(20,30) n=2", x_out, y_out, count_out);
        end
        pix(201, 10, RED);
        pix(300, 31, RED);
        pix(400, 50, RED);
        pix(0, 0, GREEN);
        run_window(40, fk, np, bt);
        checks++;
        if (fk != 33 || np != 1) begin
            failures++;
            $display("FAIL overrun_next_pulse at=%0d count=%0d want at=33 count=1", fk, np);
        end
        checks++;
        if (x_out !== 11'd300 || y_out !== 10'd30 || count_out !== 20'd3 || found_out !== 1'b1) begin
            failures++;
            $display("FAIL overrun_next got=(%0d,%0d) n=%0d f=%b want=(300,30) n=3 f=1",
                     x_out, y_out, count_out, found_out);
        end
    endtask

    task automatic test_reset_mid_divide();
        int np;
        np = 0;
        pix(100, 50, RED);
        pix(102, 50, RED);
        pix(104, 56, RED);
        pix(0, 0, GREEN);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            pixel_valid_in = 1'b0;
            if (centroid_valid_out === 1'b1) np++;
            if (k == 15) begin
                checks++;
                if (busy_out !== 1'b1) begin
                    failures++;
                    $display("FAIL rst_busy_before got=%b want=1", busy_out);
                end
                rst_in = 1'b1;
            end
            if (k == 16) begin
                checks++;
                if (busy_out !== 1'b0 || centroid_valid_out !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_busy_after busy=%b valid=%b want 0 0", busy_out, centroid_valid_out);
                end
                checks++;
                if (x_out !== 11'd0 || y_out !== 10'd0 || count_out !== 20'd0 ||
                    found_out !== 1'b0 || mask_valid_out !== 1'b0) begin
                    failures++;
                    $display("FAIL rst_outputs x=%0d y=%0d n=%0d f=%b mv=%b want all 0",
                             x_out, y_out, count_out, found_out, mask_valid_out);
                end
                rst_in = 1'b0;
            end
        end
        checks++;
        if (np != 0) begin
            failures++;
            $display("FAIL rst_no_pulse got=%0d want=0", np);
        end
    endtask

    initial begin
        test_reset();
        test_mask();
        test_centroid();
        test_empty_frame();
        test_overrun();
        test_reset_mid_divide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
